window_capture: RTL and testbench
=================================

WINDOW_CAPTURE -- requirements
Module: window_capture

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of input channels (>=1).
REQ-002 SHALL have parameter DW, default 14, sample width per channel.
REQ-003 SHALL have parameter OW, default 16, output word width (OW >= DW).
REQ-004 SHALL have parameter TURN_MAX, default 50000, one_turn edges per period.
REQ-005 SHALL have parameter WIN_START, default 49820, turn index of first captured point.
REQ-006 SHALL have parameter WIN_PTS, default 180, points per window (WIN_START+WIN_PTS <= TURN_MAX).
REQ-007 SHALL have port Clk input 1: single clock, all logic on rising edge.
REQ-008 SHALL have port Rst input 1: asynchronous, active-high reset.
REQ-009 SHALL have port one_turn input 1: asynchronous "all channels converted" strobe.
REQ-010 SHALL have port Samp_en input 1: turn counting and capture enable.
REQ-011 SHALL have port arm_mode input 1: 0 = continuous, 1 = single-shot.
REQ-012 SHALL have port arm input 1: one-cycle pulse starting a single-shot capture.
REQ-013 SHALL have port data_in input CH_NUM*DW: channel k in bits [k*DW+DW-1 : k*DW].
REQ-014 SHALL have ports out_data output OW, out_valid output 1, out_ready input 1, out_last output 1: readout stream.
REQ-015 SHALL have ports busy output 1 (state != IDLE) and overrun output 1 (sticky error).

Function
REQ-016 SHALL pass one_turn through a 2-flop synchroniser plus 1 history flop; edge pulse = rising edge, one cycle wide, 3 Clk after the input rises.
REQ-017 SHALL count edges in turn_cnt (0..TURN_MAX-1) while Samp_en=1, wrapping TURN_MAX-1 -> 0 on the edge itself; Samp_en=0 clears turn_cnt to 0 and returns the FSM to IDLE (no output word emitted).
REQ-018 SHALL implement FSM IDLE, WAIT, CAPT, DRAIN.
REQ-019 IDLE -> WAIT when Samp_en=1 and (arm_mode=0, or arm=1); arm outside IDLE ignored.
REQ-020 WAIT -> CAPT on the edge that takes turn_cnt to WIN_START; that edge is point 0.
REQ-021 In CAPT each edge SHALL snapshot all of data_in, then write CH_NUM words on the next CH_NUM cycles, channel 0 first, to internal buffer address pt*CH_NUM+ch (depth CH_NUM*WIN_PTS).
REQ-022 An edge arriving while a write burst is in progress SHALL be ignored and set overrun; point count not advanced.
REQ-023 After WIN_PTS bursts complete, CAPT -> DRAIN.
REQ-024 DRAIN SHALL stream addresses 0..CH_NUM*WIN_PTS-1 in order; out_data = sample zero-extended to OW; out_last=1 on final word only.
REQ-025 Handshake: word transfers when out_valid & out_ready; out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0; out_valid=0 outside DRAIN; no bubbles required when out_ready held high after first word (at most 1 cycle buffer read latency before first word).
REQ-026 After final transfer DRAIN -> IDLE (single-shot) or WAIT (continuous).
REQ-027 In continuous mode, if the WIN_START edge occurs while in DRAIN, that window SHALL be skipped and overrun set; turn_cnt keeps counting regardless of state.
REQ-028 overrun SHALL clear only on reset.

Reset
REQ-029 Rst=1 SHALL immediately force: state IDLE, turn_cnt 0, synchroniser flops 0, out_valid 0, out_last 0, out_data 0, busy 0, overrun 0; buffer contents undefined.
REQ-030 Reset mid-CAPT or mid-DRAIN SHALL abandon the frame; after release no word is output until a new window completes.

Verification (CH_NUM=2, DW=4, OW=8, TURN_MAX=10, WIN_START=6, WIN_PTS=3, edges every 8 Clk)
REQ-031 Continuous, out_ready=1, data_in = {ch1=point+8, ch0=point}: -> 6 words 00,08,01,09,02,0A, out_last on 0A, repeated every period, overrun=0.
REQ-032 Single-shot, no arm -> busy=0, no out_valid over 3 periods; one arm pulse -> exactly one 6-word frame, then busy=0.
REQ-033 out_ready toggled randomly in DRAIN -> same 6-word sequence, out_data stable during every stall.
REQ-034 Edge spacing 1 Clk during CAPT -> overrun=1, second edge dropped, frame still 6 words.
REQ-035 out_ready=0 for a full period in continuous mode -> next window skipped, overrun=1, stalled frame delivered intact.
REQ-036 Rst pulsed mid-DRAIN, or Samp_en dropped -> out_valid=0 next cycle, turn_cnt=0, next frame correct.

Source files
------------

// File: rtl/window_capture.sv
// Turn-synchronous window capture: snapshots CH_NUM channels on WIN_PTS consecutive
// one_turn edges starting at WIN_START, buffers them, then streams them out in order.
module window_capture #(
    parameter int CH_NUM    = 4,
    parameter int DW        = 14,
    parameter int OW        = 16,
    parameter int TURN_MAX  = 50000,
    parameter int WIN_START = 49820,
    parameter int WIN_PTS   = 180
) (
    input  logic                                         Clk,
    input  logic                                         Rst,
    input  logic                                         one_turn,
    input  logic                                         Samp_en,
    input  logic                                         arm_mode,
    input  logic                                         arm,
    input  logic [CH_NUM*DW-1:0]                         data_in,
    output logic [OW-1:0]                                out_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_last,
    output logic                                         busy,
    output logic                                         overrun,
    output logic [1:0]                                   dbg_state,
    output logic [$clog2(TURN_MAX > 1 ? TURN_MAX : 2)-1:0] dbg_turn_cnt
);

    localparam int DEPTH = CH_NUM * WIN_PTS;
    localparam int AW    = $clog2(DEPTH > 1 ? DEPTH : 2);
    localparam int CW    = $clog2(CH_NUM > 1 ? CH_NUM : 2);
    localparam int PW    = $clog2(WIN_PTS > 1 ? WIN_PTS : 2);
    localparam int TW    = $clog2(TURN_MAX > 1 ? TURN_MAX : 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CAPT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    logic          sync1, sync2, sync3;
    logic          edge_p;
    logic [TW-1:0] turn_cnt, turn_next;
    logic          win_hit;

    logic          wr_active;
    logic [CW-1:0] wr_ch;
    logic [PW-1:0] pt_cnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] snap [CH_NUM];
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] rd_addr;
    logic          rd_done;

    logic          burst_last_ch;
    logic          burst_done_last;
    logic          start_burst;
    logic          final_xfer;

    // one_turn is asynchronous: two flops to resolve metastability, a third for edge history.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= one_turn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_p    = sync2 & ~sync3;
    assign turn_next = (turn_cnt == TW'(TURN_MAX - 1)) ? '0 : turn_cnt + TW'(1);
    assign win_hit   = edge_p && (turn_next == TW'(WIN_START));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            turn_cnt <= '0;
        end else if (!Samp_en) begin
            turn_cnt <= '0;
        end else if (edge_p) begin
            turn_cnt <= turn_next;
        end
    end

    assign burst_last_ch   = wr_active && (wr_ch == CW'(CH_NUM - 1));
    assign burst_done_last = burst_last_ch && (pt_cnt == PW'(WIN_PTS - 1));
    assign start_burst     = Samp_en && edge_p && !wr_active &&
                             ((state == WAIT && win_hit) || state == CAPT);
    assign final_xfer      = out_valid && out_ready && out_last;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!Samp_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (!arm_mode || arm) state_next = WAIT;
                WAIT:    if (win_hit) state_next = CAPT;
                CAPT:    if (burst_done_last) state_next = DRAIN;
                DRAIN:   if (final_xfer) state_next = arm_mode ? IDLE : WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Each accepted edge latches all channels, then writes one channel per cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_active <= 1'b0;
            wr_ch     <= '0;
            pt_cnt    <= '0;
            wr_addr   <= '0;
            for (int k = 0; k < CH_NUM; k++) snap[k] <= '0;
        end else if (!Samp_en) begin
            wr_active <= 1'b0;
            wr_ch     <= '0;
            pt_cnt    <= '0;
            wr_addr   <= '0;
        end else if (start_burst) begin
            for (int k = 0; k < CH_NUM; k++) snap[k] <= data_in[k*DW +: DW];
            wr_active <= 1'b1;
            wr_ch     <= '0;
        end else if (wr_active) begin
            wr_addr <= wr_addr + AW'(1);
            if (burst_last_ch) begin
                wr_active <= 1'b0;
                wr_ch     <= '0;
                pt_cnt    <= (pt_cnt == PW'(WIN_PTS - 1)) ? '0 : pt_cnt + PW'(1);
            end else begin
                wr_ch <= wr_ch + CW'(1);
            end
        end else if (state != CAPT) begin
            wr_addr <= '0;
            pt_cnt  <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_active) mem[wr_addr] <= snap[wr_ch];
    end

    // Dropped edge mid-burst, or a continuous-mode window starting while still draining.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overrun <= 1'b0;
        end else if (Samp_en && edge_p &&
                     ((state == CAPT && wr_active) ||
                      (state == DRAIN && win_hit && !arm_mode))) begin
            overrun <= 1'b1;
        end
    end

    // Stream: a word moves on a cycle with out_valid & out_ready; while out_valid is high
    // and out_ready low, out_data/out_last hold. A new word loads whenever the slot is
    // empty or being emptied, so a held-high out_ready sees one word per cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            rd_addr   <= '0;
            rd_done   <= 1'b0;
        end else if (!Samp_en || state != DRAIN) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_addr   <= '0;
            rd_done   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (rd_done) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                out_data  <= OW'(mem[rd_addr]);
                out_last  <= (rd_addr == AW'(DEPTH - 1));
                if (rd_addr == AW'(DEPTH - 1)) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign dbg_state    = state;
    assign dbg_turn_cnt = turn_cnt;

endmodule

// File: tb/tb_window_capture.sv
// Bench for window_capture: CH_NUM=2, DW=4, OW=8, TURN_MAX=10, WIN_START=6, WIN_PTS=3,
// one_turn edges every 8 clocks; words are predicted when the points are driven.
module tb_window_capture;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       one_turn;
    logic       Samp_en;
    logic       arm_mode;
    logic       arm;
    logic [7:0] data_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       overrun;
    logic [1:0] dbg_state;
    logic [3:0] dbg_turn_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         tb_turn = 0;
    bit         rand_ready = 0;
    bit         ready_hold = 0;

    window_capture #(
        .CH_NUM(2), .DW(4), .OW(8), .TURN_MAX(10), .WIN_START(6), .WIN_PTS(3)
    ) dut (
        .Clk(Clk), .Rst(Rst), .one_turn(one_turn), .Samp_en(Samp_en),
        .arm_mode(arm_mode), .arm(arm), .data_in(data_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state), .dbg_turn_cnt(dbg_turn_cnt)
    );

    always #5 Clk = ~Clk;

    // Scoreboard: pops on each handshake, watches stalls and bubbles.
    bit         stall_prev = 0;
    bit         xfer_prev = 0;
    logic [8:0] stall_val;
    logic [8:0] got;
    logic [8:0] exp_w;

    always @(negedge Clk) begin
        if (Rst !== 1'b0) begin
            stall_prev = 0;
            xfer_prev  = 0;
        end else begin
            got = {out_last, out_data};
            if (stall_prev && Samp_en) begin
                checks++;
                if (out_valid !== 1'b1 || got !== stall_val) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b word=%h, need valid=1 word=%h", out_valid, got, stall_val);
                end
            end
            if (xfer_prev && ready_hold && Samp_en) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bubble: valid=%b after non-last word, need 1", out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid: word=%h with nothing expected", got);
                end else if (out_ready === 1'b1) begin
                    exp_w = exp_q.pop_front();
                    checks++;
                    if (got !== exp_w) begin
                        errors++;
                        $display("FAIL word: got last/data=%h, need %h", got, exp_w);
                    end
                end
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            stall_val  = got;
            xfer_prev  = (out_valid === 1'b1) && (out_ready === 1'b1) && (out_last === 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic cyc();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        tick(1);
    endtask

    // One 8-clock turn period; dbl adds a second rising edge two clocks after the first.
    task automatic drive_pulse(input logic [7:0] d, input bit dbl);
        data_in  = d;
        one_turn = 1'b1;
        cyc();
        if (dbl) begin
            one_turn = 1'b0;
            cyc();
            one_turn = 1'b1;
            cyc();
            one_turn = 1'b0;
            repeat (5) cyc();
        end else begin
            cyc();
            one_turn = 1'b0;
            repeat (6) cyc();
        end
    endtask

    task automatic run_turn(input bit want);
        int         pt;
        logic [7:0] d;
        tb_turn = (tb_turn + 1) % 10;
        if (tb_turn >= 6 && tb_turn < 9) begin
            pt = tb_turn - 6;
            d  = {4'(pt + 8), 4'(pt)};
            if (want) begin
                exp_q.push_back({1'b0, 8'(pt)});
                exp_q.push_back({(pt == 2), 8'(pt + 8)});
            end
        end else begin
            d = 8'hC3 ^ 8'(tb_turn);
        end
        drive_pulse(d, 1'b0);
    endtask

    task automatic run_period(input bit want);
        for (int t = 0; t < 10; t++) run_turn(want);
    endtask

    task automatic start_run(input bit mode);
        Samp_en  = 1'b0;
        arm_mode = mode;
        arm      = 1'b0;
        one_turn = 1'b0;
        exp_q.delete();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
        tick(1);
        Samp_en = 1'b1;
        tb_turn = 0;
        tick(1);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b need 0", out_last); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h need 00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b need 0", overrun); end
        checks++; if (dbg_turn_cnt !== 4'd0) begin errors++; $display("FAIL rst_turn: got %0d need 0", dbg_turn_cnt); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d need 0", dbg_state); end
        Rst = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_continuous();
        start_run(1'b0);
        out_ready  = 1'b1;
        ready_hold = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b need 1", busy); end
        for (int p = 0; p < 3; p++) run_period(1'b1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cont_left: got %0d words pending, need 0", exp_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cont_overrun: got %b need 0", overrun); end
        checks++; if (dbg_turn_cnt !== 4'd0) begin errors++; $display("FAIL cont_turn: got %0d need 0", dbg_turn_cnt); end
        ready_hold = 0;
    endtask

    task automatic test_single_shot();
        start_run(1'b1);
        out_ready  = 1'b1;
        ready_hold = 1;
        for (int t = 0; t < 30; t++) begin
            run_turn(1'b0);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL ss_unarmed_busy: got %b need 0 (turn %0d)", busy, t); end
        end
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_armed_busy: got %b need 1", busy); end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL ss_armed_state: got %0d need 1", dbg_state); end
        run_period(1'b1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ss_left: got %0d words pending, need 0", exp_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_done_busy: got %b need 0", busy); end
        run_period(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_after_busy: got %b need 0", busy); end
        ready_hold = 0;
    endtask

    task automatic test_stall_random();
        start_run(1'b0);
        rand_ready = 1;
        for (int p = 0; p < 2; p++) run_period(1'b1);
        rand_ready = 0;
        out_ready  = 1'b1;
        tick(12);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_left: got %0d words pending, need 0", exp_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rr_overrun: got %b need 0", overrun); end
    endtask

    task automatic test_overrun_capt();
        start_run(1'b0);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) run_turn(1'b1);
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h008);
        drive_pulse(8'h80, 1'b1);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL capt_overrun: got %b need 1", overrun); end
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h009);
        drive_pulse(8'h91, 1'b0);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h10A);
        drive_pulse(8'hA2, 1'b0);
        tick(8);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL capt_left: got %0d words pending, need 0", exp_q.size()); end
        checks++; if (dbg_turn_cnt !== 4'd9) begin errors++; $display("FAIL capt_turn: got %0d need 9", dbg_turn_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL capt_sticky: got %b need 1", overrun); end
    endtask

    task automatic test_stall_skip();
        start_run(1'b0);
        out_ready = 1'b0;
        run_period(1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL skip_pre_overrun: got %b need 0", overrun); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL skip_held_valid: got %b need 1", out_valid); end
        run_period(1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL skip_overrun: got %b need 1", overrun); end
        out_ready = 1'b1;
        run_period(1'b1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL skip_left: got %0d words pending, need 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        start_run(1'b0);
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) run_turn(1'b1);
        Rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ab_rst_valid: got %b need 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL ab_rst_data: got %h need 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL ab_rst_last: got %b need 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_rst_busy: got %b need 0", busy); end
        checks++; if (dbg_turn_cnt !== 4'd0) begin errors++; $display("FAIL ab_rst_turn: got %0d need 0", dbg_turn_cnt); end
        checks++;
        if (exp_q.size() < 1 || exp_q.size() > 5) begin errors++; $display("FAIL ab_rst_middrain: got %0d pending, need 1..5", exp_q.size()); end
        exp_q.delete();
        tick(2);
        Rst = 1'b0;
        tb_turn = 0;
        tick(1);
        run_period(1'b1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ab_rst_left: got %0d pending, need 0", exp_q.size()); end

        for (int t = 0; t < 8; t++) run_turn(1'b1);
        Samp_en = 1'b0;
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ab_en_valid: got %b need 0", out_valid); end
        checks++; if (dbg_turn_cnt !== 4'd0) begin errors++; $display("FAIL ab_en_turn: got %0d need 0", dbg_turn_cnt); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL ab_en_state: got %0d need 0", dbg_state); end
        checks++;
        if (exp_q.size() < 1 || exp_q.size() > 5) begin errors++; $display("FAIL ab_en_middrain: got %0d pending, need 1..5", exp_q.size()); end
        exp_q.delete();
        tick(3);
        Samp_en = 1'b1;
        tb_turn = 0;
        tick(1);
        run_period(1'b1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ab_en_left: got %0d pending, need 0", exp_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ab_overrun: got %b need 0", overrun); end
    endtask

    initial begin
        Rst       = 1'b1;
        one_turn  = 1'b0;
        Samp_en   = 1'b0;
        arm_mode  = 1'b0;
        arm       = 1'b0;
        out_ready = 1'b0;
        data_in   = 8'h00;
        test_reset();
        test_continuous();
        test_single_shot();
        test_stall_random();
        test_overrun_capt();
        test_stall_skip();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
